mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller_if.sv | 32 +++
 rtl/mc_controller.sv | 175 +++++++++++++++++
 tb/tb_mc_controller.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_if.sv
// Control bus between the multicycle MIPS main controller (master) and its datapath (slave).
interface mc_controller_if #(
    parameter int unsigned OP_WIDTH    = 6,
    parameter int unsigned CNTRL_WIDTH = 3
);
    logic [OP_WIDTH-1:0]    op;
    logic [OP_WIDTH-1:0]    funct;
    logic                   zero;
    logic                   iord;
    logic                   memwrite;
    logic                   irwrite;
    logic                   regdst;
    logic                   memtoreg;
    logic                   regwrite;
    logic                   alusrca;
    logic [1:0]             alusrcb;
    logic [1:0]             pcsrc;
    logic [CNTRL_WIDTH-1:0] alucontrol;
    logic                   pcen;

    modport master (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
        output alusrcb, pcsrc, alucontrol, pcen
    );

    modport slave (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
        input  alusrcb, pcsrc, alucontrol, pcen
    );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM with registered state decode, plus
// combinational ALU-control decode and PC-enable logic.
module mc_controller #(
    parameter int unsigned CNTRL_WIDTH = 3,
    parameter int unsigned OP_WIDTH    = 6
) (
    input logic             clk,
    input logic             reset,
    mc_controller_if.master bus
);
    localparam logic [OP_WIDTH-1:0] OpLw    = OP_WIDTH'(6'b100011);
    localparam logic [OP_WIDTH-1:0] OpSw    = OP_WIDTH'(6'b101011);
    localparam logic [OP_WIDTH-1:0] OpRtype = OP_WIDTH'(6'b000000);
    localparam logic [OP_WIDTH-1:0] OpBeq   = OP_WIDTH'(6'b000100);
    localparam logic [OP_WIDTH-1:0] OpAddi  = OP_WIDTH'(6'b001000);
    localparam logic [OP_WIDTH-1:0] OpJ     = OP_WIDTH'(6'b000010);

    localparam logic [OP_WIDTH-1:0] FnAdd = OP_WIDTH'(6'b100000);
    localparam logic [OP_WIDTH-1:0] FnSub = OP_WIDTH'(6'b100010);
    localparam logic [OP_WIDTH-1:0] FnAnd = OP_WIDTH'(6'b100100);
    localparam logic [OP_WIDTH-1:0] FnOr  = OP_WIDTH'(6'b100101);
    localparam logic [OP_WIDTH-1:0] FnSlt = OP_WIDTH'(6'b101010);

    localparam logic [CNTRL_WIDTH-1:0] AluAdd = CNTRL_WIDTH'(3'b010);
    localparam logic [CNTRL_WIDTH-1:0] AluSub = CNTRL_WIDTH'(3'b110);
    localparam logic [CNTRL_WIDTH-1:0] AluAnd = CNTRL_WIDTH'(3'b000);
    localparam logic [CNTRL_WIDTH-1:0] AluOr  = CNTRL_WIDTH'(3'b001);
    localparam logic [CNTRL_WIDTH-1:0] AluSlt = CNTRL_WIDTH'(3'b111);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
        StRtypeEx, StRtypeWb, StBeqEx, StAddiEx, StAddiWb, StJEx
    } state_e;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    function automatic ctrl_t decode(input state_e st);
        ctrl_t c;
        c = '0;
        case (st)
            StFetch: begin
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.alusrcb = 2'b01;
            end
            StDecode:  c.alusrcb = 2'b11;
            StMemAdr, StAddiEx: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            StMemRd:   c.iord = 1'b1;
            StMemWb: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            StMemWr: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            StRtypeEx: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            StRtypeWb: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            StBeqEx: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            StAddiWb:  c.regwrite = 1'b1;
            StJEx: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    ctrl_t  ctrl;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:   state_d = StDecode;
            StDecode: begin
                case (bus.op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StRtypeEx;
                    OpBeq:      state_d = StBeqEx;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJEx;
                    default:    state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = (bus.op == OpLw) ? StMemRd : StMemWr;
            StMemRd:   state_d = StMemWb;
            StRtypeEx: state_d = StRtypeWb;
            StAddiEx:  state_d = StAddiWb;
            default:   state_d = StFetch;
        endcase
        // Outputs are registered alongside the state so they track it exactly.
        ctrl_d = decode(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            ctrl_q  <= decode(StFetch);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // While reset is held the outputs show the FETCH decode with every write suppressed.
    always_comb begin
        ctrl = reset ? decode(StFetch) : ctrl_q;
        if (reset) begin
            ctrl.irwrite  = 1'b0;
            ctrl.memwrite = 1'b0;
            ctrl.regwrite = 1'b0;
            ctrl.pcwrite  = 1'b0;
            ctrl.branch   = 1'b0;
        end
    end

    always_comb begin
        bus.alucontrol = AluAdd;
        case (ctrl.aluop)
            2'b01: bus.alucontrol = AluSub;
            2'b10: begin
                case (bus.funct)
                    FnAdd:   bus.alucontrol = AluAdd;
                    FnSub:   bus.alucontrol = AluSub;
                    FnAnd:   bus.alucontrol = AluAnd;
                    FnOr:    bus.alucontrol = AluOr;
                    FnSlt:   bus.alucontrol = AluSlt;
                    default: bus.alucontrol = AluAdd;
                endcase
            end
            default: bus.alucontrol = AluAdd;
        endcase
    end

    assign bus.iord     = ctrl.iord;
    assign bus.memwrite = ctrl.memwrite;
    assign bus.irwrite  = ctrl.irwrite;
    assign bus.regdst   = ctrl.regdst;
    assign bus.memtoreg = ctrl.memtoreg;
    assign bus.regwrite = ctrl.regwrite;
    assign bus.alusrca  = ctrl.alusrca;
    assign bus.alusrcb  = ctrl.alusrcb;
    assign bus.pcsrc    = ctrl.pcsrc;
    assign bus.pcen     = ctrl.pcwrite | (ctrl.branch & bus.zero);
endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: an instruction-level model predicts every cycle's
// control outputs, with a few hand-written literal expectations pinning the model.
module tb_mc_controller;
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       pcen;
    } out_t;

    logic  clk = 1'b0;
    logic  reset;
    int    n_checks = 0;
    int    n_pass = 0;
    out_t  exp_v;
    logic  exp_valid = 1'b0;
    string exp_tag = "";
    out_t  none = '0;

    mc_controller_if #(.OP_WIDTH(6), .CNTRL_WIDTH(3)) bus ();

    mc_controller #(.CNTRL_WIDTH(3), .OP_WIDTH(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Instruction classes: 0 unsupported, 1 lw, 2 sw, 3 R-type, 4 beq, 5 addi, 6 j.
    function automatic int cls_of(input logic [5:0] op);
        case (op)
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000000: return 3;
            6'b000100: return 4;
            6'b001000: return 5;
            6'b000010: return 6;
            default:   return 0;
        endcase
    endfunction

    function automatic int ncycles(input int k);
        int tbl [7] = '{2, 5, 4, 4, 3, 4, 3};
        return tbl[k];
    endfunction

    function automatic logic [2:0] alu_of_funct(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Outputs for cycle c (1-based) of an instruction, from its architectural effect.
    function automatic out_t model(input logic [5:0] op, input logic [5:0] funct, input int c,
                                   input logic zero, input logic rst);
        out_t o;
        int   k;
        o = '0;
        o.alucontrol = 3'b010;
        k = cls_of(op);
        if (rst) begin
            o.alusrcb = 2'b01;
            return o;
        end
        if (c == 1) begin
            o.irwrite = 1'b1;
            o.pcen    = 1'b1;
            o.alusrcb = 2'b01;
        end else if (c == 2) begin
            o.alusrcb = 2'b11;
        end else if (c == 3) begin
            if (k == 1 || k == 2 || k == 5) begin
                o.alusrca = 1'b1;
                o.alusrcb = 2'b10;
            end else if (k == 3) begin
                o.alusrca    = 1'b1;
                o.alucontrol = alu_of_funct(funct);
            end else if (k == 4) begin
                o.alusrca    = 1'b1;
                o.pcsrc      = 2'b01;
                o.alucontrol = 3'b110;
                o.pcen       = zero;
            end else if (k == 6) begin
                o.pcsrc = 2'b10;
                o.pcen  = 1'b1;
            end
        end else if (c == 4) begin
            if (k == 1) o.iord = 1'b1;
            if (k == 2) begin
                o.iord     = 1'b1;
                o.memwrite = 1'b1;
            end
            if (k == 3) begin
                o.regdst   = 1'b1;
                o.regwrite = 1'b1;
            end
            if (k == 5) o.regwrite = 1'b1;
        end else if (c == 5 && k == 1) begin
            o.memtoreg = 1'b1;
            o.regwrite = 1'b1;
        end
        return o;
    endfunction

    function automatic out_t dut_out();
        return {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg, bus.regwrite,
                bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.pcen};
    endfunction

    task automatic check(input string name, input out_t got, input out_t want);
        n_checks++;
        if (got !== want) $display("FAIL %s: got %b want %b", name, got, want);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (exp_valid) check(exp_tag, dut_out(), exp_v);
    end

    // Runs one instruction from its FETCH cycle; reset is raised in cycle abort_at.
    // Inputs the controller must ignore are randomized in those cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input logic zbr,
                             input int abort_at, input string tag, input int pin_c,
                             input out_t pin_v);
        int   k;
        int   n;
        logic z;
        logic rst;
        k = cls_of(op);
        n = ncycles(k);
        for (int c = 1; c <= n; c++) begin
            rst       = (c == abort_at);
            bus.op    = (c == 2 || (c == 3 && (k == 1 || k == 2))) ? op : 6'($urandom);
            bus.funct = (c == 3 && k == 3) ? funct : 6'($urandom);
            z         = (c == 3 && k == 4) ? zbr : 1'($urandom);
            bus.zero  = z;
            reset     = rst;
            exp_v     = model(op, funct, c, z, rst);
            exp_tag   = $sformatf("%s c%0d", tag, c);
            exp_valid = 1'b1;
            if (c == pin_c) begin
                #1;
                check({tag, "_pin"}, dut_out(), pin_v);
            end
            @(posedge clk);
            #1;
            if (rst) begin
                reset = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        logic [5:0] ops [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                                6'b000010, 6'b111111};
        logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                6'b111111};
        out_t p_rst, p_fetch, p_lw5, p_and, p_beq1, p_beq0, p_sw4, p_j3;
        logic [5:0] op;
        logic [5:0] fn;

        p_rst = '0;   p_rst.alusrcb = 2'b01;   p_rst.alucontrol = 3'b010;
        p_fetch = p_rst; p_fetch.irwrite = 1'b1; p_fetch.pcen = 1'b1;
        p_lw5 = '0;   p_lw5.memtoreg = 1'b1;   p_lw5.regwrite = 1'b1; p_lw5.alucontrol = 3'b010;
        p_and = '0;   p_and.alusrca = 1'b1;    p_and.alucontrol = 3'b000;
        p_beq1 = '0;  p_beq1.alusrca = 1'b1;   p_beq1.pcsrc = 2'b01;
        p_beq1.alucontrol = 3'b110;            p_beq1.pcen = 1'b1;
        p_beq0 = p_beq1; p_beq0.pcen = 1'b0;
        p_sw4 = '0;   p_sw4.iord = 1'b1;       p_sw4.memwrite = 1'b1; p_sw4.alucontrol = 3'b010;
        p_j3 = '0;    p_j3.pcsrc = 2'b10;      p_j3.pcen = 1'b1;      p_j3.alucontrol = 3'b010;

        reset = 1'b1;
        bus.op = '0;
        bus.funct = '0;
        bus.zero = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_outputs", dut_out(), p_rst);
        #1;
        reset = 1'b0;

        run_instr(6'b100011, 6'b0, 1'b0, 0, "lw_first", 1, p_fetch);
        run_instr(6'b100011, 6'b0, 1'b0, 0, "lw", 5, p_lw5);
        for (int i = 0; i < 6; i++) begin
            run_instr(6'b000000, fns[i], 1'b0, 0, $sformatf("rtype_f%b", fns[i]),
                      (i == 2) ? 3 : 0, p_and);
        end
        run_instr(6'b000100, 6'b0, 1'b1, 0, "beq_taken", 3, p_beq1);
        run_instr(6'b000100, 6'b0, 1'b0, 0, "beq_not", 3, p_beq0);
        run_instr(6'b101011, 6'b0, 1'b0, 0, "sw", 4, p_sw4);
        run_instr(6'b000010, 6'b0, 1'b0, 0, "j", 3, p_j3);
        run_instr(6'b111111, 6'b0, 1'b0, 0, "unsup", 0, none);
        run_instr(6'b001000, 6'b0, 1'b0, 0, "addi", 0, none);
        run_instr(6'b100011, 6'b0, 1'b0, 4, "lw_rst", 4, p_rst);
        run_instr(6'b001000, 6'b0, 1'b0, 0, "after_rst", 1, p_fetch);

        for (int i = 0; i < 300; i++) begin
            int oi;
            int fi;
            oi = int'($urandom_range(0, 7));
            op = (oi == 7) ? 6'($urandom) : ops[oi];
            fi = int'($urandom_range(0, 6));
            fn = (fi == 6) ? 6'($urandom) : fns[fi];
            run_instr(op, fn, 1'($urandom),
                      ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 5)) : 0,
                      $sformatf("rnd%0d_op%b", i, op), 0, none);
        end

        exp_valid = 1'b0;
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
